// File: rtl/rs422_uart_tx.sv
// Byte FIFO plus 8N1/8E1/8O1/8N2 serialiser; bit timing from clk_baud rising edges, 16 clocks per bit.
// Start bit 1..17 clocks after push into an idle block; tx_ready drops while the FIFO is full and such pushes are dropped.
module rs422_uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk1_8m,
    input  logic                 rst,
    input  logic                 clk_baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int BCW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0]  FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS);
    localparam logic [1:0]     NUM_STOPS = 2'(STOP_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]             stop_cnt_q, stop_cnt_d;
    logic                   par_q, par_d;
    logic                   txd_q, txd_d;
    logic                   busy_q;
    logic                   baud_q;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q, count_d;
    logic                   tick, push, pop;

    assign tick     = clk_baud & ~baud_q;
    assign tx_ready = (count_q != FULL_CNT);
    assign push     = tx_valid & tx_ready;
    assign txd      = txd_q;
    assign busy     = busy_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        par_d   = 1'b0;
                        txd_d   = 1'b0;
                        state_d = START;
                    end
                end
                START: begin
                    txd_d     = shift_q[0];
                    par_d     = par_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = BCW'(1);
                    state_d   = DATA;
                end
                DATA: begin
                    if (bit_cnt_q < LAST_BIT) begin
                        txd_d     = shift_q[0];
                        par_d     = par_q ^ shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (PARITY != 0) begin
                        // even parity sends the XOR itself so the total count of ones is even
                        txd_d   = (PARITY == 2) ? par_q : ~par_q;
                        state_d = PAR;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 2'd1;
                        state_d    = STOP;
                    end
                end
                PAR: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 2'd1;
                    state_d    = STOP;
                end
                STOP: begin
                    if (stop_cnt_q < NUM_STOPS) begin
                        stop_cnt_d = stop_cnt_q + 2'd1;
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        par_d   = 1'b0;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk1_8m) begin
        if (push) mem[wr_ptr_q] <= tx_data;
    end

    always_ff @(posedge clk1_8m) begin
        if (rst) begin
            // baud_q starts high so a clk_baud already high at release is not taken as an edge
            baud_q     <= 1'b1;
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            baud_q     <= clk_baud;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= (state_d != IDLE) | (count_d != '0);
            count_q    <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_rs422_uart_tx.sv
// Three transmitter variants (8N1, 8E1, 8O2) driven in lockstep and compared each cycle against a frame-level model.
module tb_rs422_uart_tx;

    localparam int FD = 4;

    logic       clk1_8m = 1'b0;
    logic       rst, clk_baud, tx_valid;
    logic [7:0] tx_data;
    logic [2:0] txd_w, rdy_w, busy_w;

    always #5 clk1_8m = ~clk1_8m;

    rs422_uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) u0 (
        .clk1_8m(clk1_8m), .rst(rst), .clk_baud(clk_baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
    rs422_uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FD)) u1 (
        .clk1_8m(clk1_8m), .rst(rst), .clk_baud(clk_baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
    rs422_uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(FD)) u2 (
        .clk1_8m(clk1_8m), .rst(rst), .clk_baud(clk_baud), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(rdy_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int par_cfg  [3] = '{0, 2, 1};
    int stop_cfg [3] = '{1, 1, 2};

    // model: per variant a byte queue, the current frame as a bit vector, and the line level
    logic [7:0]  qm [3][FD];
    int          qn [3];
    logic [15:0] fvec [3];
    int          flen [3];
    int          fpos [3];
    bit          in_fr [3];
    bit          mline [3];
    bit          m_prev;

    bit          baud_run;
    bit          baud_hold;
    logic [3:0]  phase;

    function automatic logic [15:0] frame_bits(input logic [7:0] b, input int par);
        logic [15:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int k = 0; k < 8; k++) v[k+1] = b[k];
        if (par == 2) v[9] = ^b;
        else if (par == 1) v[9] = ~^b;
        return v;
    endfunction

    function automatic int frame_len(input int par, input int stops);
        return 9 + ((par != 0) ? 1 : 0) + stops;
    endfunction

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s u%0d cyc %0d got %0h expected %0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit cb, input bit v, input logic [7:0] d);
        bit tk;
        int qp;
        if (r) begin
            m_prev = 1'b1;
            for (int i = 0; i < 3; i++) begin
                qn[i] = 0; in_fr[i] = 1'b0; mline[i] = 1'b1; fpos[i] = 0; flen[i] = 0;
            end
            return;
        end
        tk     = cb && !m_prev;
        m_prev = cb;
        for (int i = 0; i < 3; i++) begin
            qp = qn[i];
            if (tk) begin
                if (in_fr[i] && fpos[i] < flen[i]) begin
                    mline[i] = fvec[i][fpos[i]];
                    fpos[i]++;
                end else if (qp > 0) begin
                    fvec[i] = frame_bits(qm[i][0], par_cfg[i]);
                    flen[i] = frame_len(par_cfg[i], stop_cfg[i]);
                    for (int k = 0; k < FD - 1; k++) qm[i][k] = qm[i][k+1];
                    qn[i]--;
                    mline[i] = fvec[i][0];
                    fpos[i]  = 1;
                    in_fr[i] = 1'b1;
                end else begin
                    in_fr[i] = 1'b0;
                    mline[i] = 1'b1;
                end
            end
            if (v && qp < FD) begin
                qm[i][qn[i]] = d;
                qn[i]++;
            end
        end
    endtask

    task automatic do_cycle(input bit r, input bit v, input logic [7:0] d);
        bit cb;
        if (baud_run) begin
            cb = phase[3];
            phase++;
        end else begin
            cb = baud_hold;
        end
        rst = r; clk_baud = cb; tx_valid = v; tx_data = d;
        model_step(r, cb, v, d);
        @(negedge clk1_8m);
        cyc++;
        for (int i = 0; i < 3; i++) begin
            chk("txd",      i, 16'(txd_w[i]),  16'(mline[i]));
            chk("tx_ready", i, 16'(rdy_w[i]),  16'(qn[i] < FD));
            chk("busy",     i, 16'(busy_w[i]), 16'(in_fr[i] || qn[i] > 0));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_start(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            if (txd_w[i] === 1'b0) ok = 1'b1;
            else do_cycle(1'b0, 1'b0, 8'h00);
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL start_timeout u%0d cyc %0d got no start bit expected one within 40 clocks", i, cyc);
        end
    endtask

    initial begin
        logic [15:0] fb;
        logic [9:0]  pat55;
        int          starts0, starts2, zeros;
        logic        prev0, prev2;

        fb = frame_bits(8'h55, 0);
        chk("pin_frame55", 0, 16'(fb[9:0]), 16'h02AA);
        fb = frame_bits(8'h07, 2);
        chk("pin_even07", 1, 16'(fb[9]), 16'd1);
        fb = frame_bits(8'h07, 1);
        chk("pin_odd07", 2, 16'(fb[9]), 16'd0);
        chk("pin_len8O2", 2, 16'(frame_len(1, 2)), 16'd12);

        rst = 1'b1; clk_baud = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        baud_run = 1'b0; baud_hold = 1'b1; phase = 4'd0;
        model_step(1'b1, 1'b1, 1'b0, 8'h00);
        @(negedge clk1_8m);
        for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, 8'h00);
        chk("rst_txd",   0, 16'(txd_w[0]),  16'd1);
        chk("rst_ready", 0, 16'(rdy_w[0]),  16'd1);
        chk("rst_busy",  0, 16'(busy_w[0]), 16'd0);

        // clk_baud held high across reset release must not start anything
        do_cycle(1'b0, 1'b1, 8'h99);
        run(20);
        chk("no_spurious_start", 0, 16'(txd_w[0]), 16'd1);

        // T1: 8N1 0x55 literal waveform
        baud_run = 1'b1;
        run(400);
        pat55 = 10'b1010101010;
        do_cycle(1'b0, 1'b1, 8'h55);
        wait_start(0);
        run(8);
        for (int k = 0; k < 10; k++) begin
            chk("t1_bit", k, 16'(txd_w[0]), 16'(pat55[k]));
            run(16);
        end
        chk("t1_idle_txd",  0, 16'(txd_w[0]),  16'd1);
        chk("t1_idle_busy", 0, 16'(busy_w[0]), 16'd0);

        // T2: parity of 0x07
        run(200);
        do_cycle(1'b0, 1'b1, 8'h07);
        wait_start(1);
        run(8 + 9 * 16);
        chk("t2_even_par", 1, 16'(txd_w[1]), 16'd1);
        chk("t2_odd_par",  2, 16'(txd_w[2]), 16'd0);
        run(32);
        chk("t2_stop2",     2, 16'(txd_w[2]),  16'd1);
        chk("t2_busy_1stop", 1, 16'(busy_w[1]), 16'd0);
        chk("t2_busy_2stop", 2, 16'(busy_w[2]), 16'd1);

        // T4: back-to-back frames
        run(250);
        do_cycle(1'b0, 1'b1, 8'hA5);
        do_cycle(1'b0, 1'b1, 8'h3C);
        wait_start(0);
        run(159);
        chk("t4_last_stop", 0, 16'(txd_w[0]), 16'd1);
        run(1);
        chk("t4_next_start", 0, 16'(txd_w[0]), 16'd0);

        // T3: fill right after a tick, fifth push dropped
        run(400);
        for (int n = 0; n < 20 && phase != 4'd9; n++) run(1);
        for (int k = 0; k < 4; k++) do_cycle(1'b0, 1'b1, 8'hFF);
        chk("t3_full", 0, 16'(rdy_w[0]), 16'd0);
        do_cycle(1'b0, 1'b1, 8'hFF);
        starts0 = 0; starts2 = 0; prev0 = txd_w[0]; prev2 = txd_w[2];
        for (int k = 0; k < 900; k++) begin
            run(1);
            if (prev0 && !txd_w[0]) starts0++;
            if (prev2 && !txd_w[2]) starts2++;
            prev0 = txd_w[0]; prev2 = txd_w[2];
        end
        chk("t3_frames", 0, 16'(starts0), 16'd4);
        chk("t3_frames", 2, 16'(starts2), 16'd4);

        // T5: reset during data bit 3 with two bytes queued
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, 8'hF0);
        wait_start(0);
        run(8 + 16 * 4);
        do_cycle(1'b1, 1'b0, 8'h00);
        chk("t5_txd",   0, 16'(txd_w[0]),  16'd1);
        chk("t5_ready", 0, 16'(rdy_w[0]),  16'd1);
        chk("t5_busy",  0, 16'(busy_w[0]), 16'd0);
        zeros = 0;
        for (int k = 0; k < 300; k++) begin
            run(1);
            if (!txd_w[0]) zeros++;
        end
        chk("t5_no_frames", 0, 16'(zeros), 16'd0);

        // stuck clk_baud: FIFO still fills, FSM frozen
        baud_run = 1'b0; baud_hold = 1'b0;
        for (int k = 0; k < 6; k++) do_cycle(1'b0, 1'b1, 8'hC3);
        chk("stuck_full", 0, 16'(rdy_w[0]),  16'd0);
        chk("stuck_busy", 0, 16'(busy_w[0]), 16'd1);
        run(50);
        baud_run = 1'b1;

        // randomized traffic with occasional stalls and resets
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                baud_run  = 1'b0;
                baud_hold = 1'($urandom_range(0, 1));
                for (int s = 0; s < 30; s++) do_cycle(1'b0, ($urandom_range(0, 3) == 0), 8'($urandom));
                baud_run = 1'b1;
            end
            do_cycle(($urandom_range(0, 1499) == 0), ($urandom_range(0, 7) == 0), 8'($urandom));
        end
        run(900);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
